// File: rtl/im_fetch_responder.sv
// im_fetch_responder
//   Instruction-memory responder sitting between the PC register and decode.
//   Accepts one fetch request (byte address = PC) via valid/ready. It looks the
//   word up in an internal word-addressed ROM and returns it after LATENCY extra
//   cycles. The response is held until the consumer takes it.
//
// Ports
//   Clk        in   1           clock, all state updates on posedge
//   Reset      in   1           synchronous active-high reset (ROM not cleared)
//   req_valid  in   1           fetch request present
//   req_addr   in   32          byte address to fetch
//   req_ready  out  1           responder can accept a request this cycle
//   rsp_valid  out  1           rsp_instr/rsp_err valid
//   rsp_instr  out  32          fetched instruction word (0 on error)
//   rsp_err    out  1           misaligned or out-of-range request
//   rsp_ready  in   1           consumer accepts response this cycle
//   flush      in   1           abort pending transaction (branch redirect)
//   ld_en      in   1           ROM write enable (program load)
//   ld_idx     in   DEPTH_LOG2  ROM word index to write
//   ld_data    in   32          ROM write data
//   fetch_cnt  out  32          count of completed response handshakes
module im_fetch_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_instr,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [31:0]           ld_data,
  output logic [31:0]           fetch_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [31:0] rsp_instr_q;
  logic        rsp_err_q;
  logic [31:0] fetch_cnt_q;
  logic [31:0] rom [DEPTH];

  logic                  accept;
  logic                  enter_resp;
  logic                  rsp_hs;
  logic [31:0]           eval_addr;
  logic [31:0]           byte_off;
  logic [31:0]           word_off;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] rom_idx;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flush wins over every handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (LAT == 4'd0) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              cnt_d   = LAT;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
        RESP: begin
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and handshake strobes
  always_comb begin
    req_ready  = (state_q == IDLE) && !flush;
    rsp_valid  = (state_q == RESP);
    accept     = req_ready && req_valid;
    rsp_hs     = rsp_valid && rsp_ready && !flush;
    enter_resp = (state_d == RESP) && (state_q != RESP);
  end

  // With zero latency RESP is entered on the accept edge itself, so the
  // incoming address is decoded directly instead of the latched copy.
  always_comb begin
    eval_addr = (state_q == IDLE) ? req_addr : addr_q;
    byte_off  = eval_addr - BASE_ADDR;
    word_off  = byte_off >> 2;
    addr_err  = (eval_addr[1:0] != 2'b00) || (eval_addr < BASE_ADDR) ||
                ((word_off >> DEPTH_LOG2) != '0);
    rom_idx   = word_off[DEPTH_LOG2-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q      <= '0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      if (accept) addr_q <= req_addr;
      if (enter_resp) begin
        rsp_instr_q <= addr_err ? '0 : rom[rom_idx];
        rsp_err_q   <= addr_err;
      end
      if (rsp_hs) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  // Program load; a read on the same edge sees the pre-write word
  always_ff @(posedge Clk) begin
    if (!Reset && ld_en) rom[ld_idx] <= ld_data;
  end

  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule
